// File: rtl/aibnd_dcc_fine_therm_ctrl.sv
// Fine-delay DCC controller: filters phase-detector votes, steps a 0..30
// fine code with a settle window after every change, drives registered
// thermometer buses (true/complement) and reports saturation and lock.
module aibnd_dcc_fine_therm_ctrl #(
  parameter int VOTE_N     = 4,
  parameter int SETTLE_CYC = 8,
  parameter int LOCK_N     = 4,
  parameter int INIT_CODE  = 15
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        dcc_en,
  input  logic        ovr_en,
  input  logic [4:0]  ovr_code,
  input  logic        pd_vld,
  input  logic        pd_up,
  output logic [4:0]  fine_code,
  output logic [14:0] therm_up,
  output logic [14:0] thermb_up,
  output logic [14:0] therm_dn,
  output logic [14:0] thermb_dn,
  output logic        sat_hi,
  output logic        sat_lo,
  output logic        dcc_lock
);

  localparam logic [1:0] ST_DIS    = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_OVR    = 2'd3;

  localparam logic [4:0] CODE_MAX    = 5'd30;
  localparam logic [4:0] CODE_INIT   = 5'(INIT_CODE);
  localparam logic [3:0] VOTE_TGT    = 4'(VOTE_N);
  localparam logic [3:0] LOCK_TGT    = 4'(LOCK_N);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  // Bit i of the 30-bit thermometer is set when the code exceeds i; the
  // low 15 bits feed the up bank, the high 15 bits the dn bank.
  function automatic logic [29:0] therm_decode(input logic [4:0] c);
    logic [29:0] t;
    for (int i = 0; i < 30; i++) begin
      t[i] = (int'(c) > i);
    end
    return t;
  endfunction

  // Override codes above the top of the line clamp to 30.
  function automatic logic [4:0] clamp_code(input logic [4:0] c);
    return (c > CODE_MAX) ? CODE_MAX : c;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic        dir_q, dir_d;
  logic [3:0]  vcnt_q, vcnt_d;
  logic [7:0]  scnt_q, scnt_d;
  logic [3:0]  rev_q, rev_d;
  logic        last_dir_q, last_dir_d;
  logic        have_last_q, have_last_d;
  logic        sat_hi_q, sat_hi_d;
  logic        sat_lo_q, sat_lo_d;
  logic        lock_q, lock_d;
  logic [14:0] therm_up_q, thermb_up_q, therm_dn_q, thermb_dn_q;
  logic [29:0] therm_nxt;
  logic [3:0]  vote_nxt;
  logic [3:0]  rev_nxt;
  logic        clr;

  // Next-state logic: mode FSM, vote filter, step commit, lock tracking.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    dir_d       = dir_q;
    vcnt_d      = vcnt_q;
    scnt_d      = scnt_q;
    rev_d       = rev_q;
    last_dir_d  = last_dir_q;
    have_last_d = have_last_q;
    sat_hi_d    = sat_hi_q;
    sat_lo_d    = sat_lo_q;
    lock_d      = lock_q;
    vote_nxt    = 4'd0;
    rev_nxt     = 4'd0;
    clr         = 1'b0;

    if (ovr_en) begin
      state_d = ST_OVR;
      code_d  = clamp_code(ovr_code);
      clr     = 1'b1;
    end else begin
      case (state_q)
        ST_OVR: begin
          state_d = ST_DIS;
          clr     = 1'b1;
        end
        ST_DIS: begin
          clr = 1'b1;
          if (dcc_en) state_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (!dcc_en) begin
            state_d = ST_DIS;
            clr     = 1'b1;
          end else if (pd_vld) begin
            if ((pd_up == dir_q) && (vcnt_q != 4'd0)) begin
              vote_nxt = vcnt_q + 4'd1;
            end else begin
              vote_nxt = 4'd1;
              dir_d    = pd_up;
            end
            if (vote_nxt == VOTE_TGT) begin
              vcnt_d = 4'd0;
              if (pd_up ? (code_q < CODE_MAX) : (code_q != 5'd0)) begin
                code_d   = pd_up ? (code_q + 5'd1) : (code_q - 5'd1);
                sat_hi_d = 1'b0;
                sat_lo_d = 1'b0;
                state_d  = ST_SETTLE;
                scnt_d   = 8'd0;
                // Reversals are counted only between code-changing steps.
                if (have_last_q && (last_dir_q != pd_up)) begin
                  rev_nxt = (rev_q == LOCK_TGT) ? rev_q : (rev_q + 4'd1);
                end else begin
                  rev_nxt = 4'd0;
                end
                rev_d       = rev_nxt;
                last_dir_d  = pd_up;
                have_last_d = 1'b1;
                if (rev_nxt == LOCK_TGT) lock_d = 1'b1;
              end else if (pd_up) begin
                sat_hi_d = 1'b1;
              end else begin
                sat_lo_d = 1'b1;
              end
            end else begin
              vcnt_d = vote_nxt;
            end
          end
        end
        ST_SETTLE: begin
          if (!dcc_en) begin
            state_d = ST_DIS;
            clr     = 1'b1;
          end else if (scnt_q == SETTLE_LAST) begin
            state_d = ST_TRACK;
            scnt_d  = 8'd0;
          end else begin
            scnt_d = scnt_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_DIS;
          clr     = 1'b1;
        end
      endcase
    end

    if (clr) begin
      vcnt_d      = 4'd0;
      scnt_d      = 8'd0;
      rev_d       = 4'd0;
      have_last_d = 1'b0;
      sat_hi_d    = 1'b0;
      sat_lo_d    = 1'b0;
      lock_d      = 1'b0;
    end

    therm_nxt = therm_decode(code_d);
  end

  // State and output registers; thermometer buses load from the next-code
  // decode so they change on the same edge as the code, glitch-free.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_DIS;
      code_q      <= CODE_INIT;
      dir_q       <= 1'b0;
      vcnt_q      <= 4'd0;
      scnt_q      <= 8'd0;
      rev_q       <= 4'd0;
      last_dir_q  <= 1'b0;
      have_last_q <= 1'b0;
      sat_hi_q    <= 1'b0;
      sat_lo_q    <= 1'b0;
      lock_q      <= 1'b0;
      therm_up_q  <= therm_decode(CODE_INIT)[14:0];
      thermb_up_q <= ~therm_decode(CODE_INIT)[14:0];
      therm_dn_q  <= therm_decode(CODE_INIT)[29:15];
      thermb_dn_q <= ~therm_decode(CODE_INIT)[29:15];
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      dir_q       <= dir_d;
      vcnt_q      <= vcnt_d;
      scnt_q      <= scnt_d;
      rev_q       <= rev_d;
      last_dir_q  <= last_dir_d;
      have_last_q <= have_last_d;
      sat_hi_q    <= sat_hi_d;
      sat_lo_q    <= sat_lo_d;
      lock_q      <= lock_d;
      therm_up_q  <= therm_nxt[14:0];
      thermb_up_q <= ~therm_nxt[14:0];
      therm_dn_q  <= therm_nxt[29:15];
      thermb_dn_q <= ~therm_nxt[29:15];
    end
  end

  assign fine_code = code_q;
  assign therm_up  = therm_up_q;
  assign thermb_up = thermb_up_q;
  assign therm_dn  = therm_dn_q;
  assign thermb_dn = thermb_dn_q;
  assign sat_hi    = sat_hi_q;
  assign sat_lo    = sat_lo_q;
  assign dcc_lock  = lock_q;

endmodule

// File: tb/tb_aibnd_dcc_fine_therm_ctrl.sv
// Bench for aibnd_dcc_fine_therm_ctrl: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the controller.
module tb_aibnd_dcc_fine_therm_ctrl;

  localparam int VOTE_N     = 4;
  localparam int SETTLE_CYC = 8;
  localparam int LOCK_N     = 4;
  localparam int INIT_CODE  = 15;

  logic        clk = 1'b0;
  logic        rstb;
  logic        dcc_en, ovr_en, pd_vld, pd_up;
  logic [4:0]  ovr_code;
  logic [4:0]  fine_code;
  logic [14:0] therm_up, thermb_up, therm_dn, thermb_dn;
  logic        sat_hi, sat_lo, dcc_lock;
  logic [67:0] act;

  int total = 0;
  int bad   = 0;

  aibnd_dcc_fine_therm_ctrl #(
    .VOTE_N(VOTE_N), .SETTLE_CYC(SETTLE_CYC), .LOCK_N(LOCK_N), .INIT_CODE(INIT_CODE)
  ) dut (
    .clk(clk), .rstb(rstb), .dcc_en(dcc_en), .ovr_en(ovr_en), .ovr_code(ovr_code),
    .pd_vld(pd_vld), .pd_up(pd_up), .fine_code(fine_code),
    .therm_up(therm_up), .thermb_up(thermb_up), .therm_dn(therm_dn), .thermb_dn(thermb_dn),
    .sat_hi(sat_hi), .sat_lo(sat_lo), .dcc_lock(dcc_lock)
  );

  always #5 clk = ~clk;

  assign act = {fine_code, therm_up, thermb_up, therm_dn, thermb_dn, sat_hi, sat_lo, dcc_lock};

  // ---------------- behavioural model ----------------
  int m_code;
  bit m_ovr, m_track;
  int m_settle;
  bit vq[$];   // current run of same-direction votes
  bit hq[$];   // directions of code-changing steps
  bit m_sh, m_sl, m_lock;

  function automatic void model_clear();
    vq.delete(); hq.delete();
    m_sh = 0; m_sl = 0; m_lock = 0;
  endfunction

  function automatic void model_reset();
    m_code = INIT_CODE; m_ovr = 0; m_track = 0; m_settle = 0;
    model_clear();
  endfunction

  function automatic void model_commit(bit up);
    int alt;
    if ((up && m_code < 30) || (!up && m_code > 0)) begin
      m_code = up ? m_code + 1 : m_code - 1;
      m_sh = 0; m_sl = 0;
      m_settle = SETTLE_CYC;
      hq.push_back(up);
      if (hq.size() > 40) void'(hq.pop_front());
      alt = 0;
      for (int i = hq.size() - 1; i > 0; i--) begin
        if (hq[i] == hq[i-1]) break;
        alt++;
      end
      if (alt >= LOCK_N) m_lock = 1;
    end else if (up) begin
      m_sh = 1;
    end else begin
      m_sl = 1;
    end
  endfunction

  function automatic void model_step();
    if (ovr_en) begin
      m_ovr = 1; m_track = 0; m_settle = 0;
      m_code = (ovr_code > 5'd30) ? 30 : int'(ovr_code);
      model_clear();
    end else if (m_ovr) begin
      m_ovr = 0; model_clear();
    end else if (!m_track) begin
      model_clear();
      if (dcc_en) m_track = 1;
    end else if (!dcc_en) begin
      m_track = 0; m_settle = 0; model_clear();
    end else if (m_settle > 0) begin
      m_settle--;
    end else if (pd_vld) begin
      if (vq.size() > 0 && vq[0] != pd_up) vq.delete();
      vq.push_back(pd_up);
      if (vq.size() == VOTE_N) begin
        vq.delete();
        model_commit(pd_up);
      end
    end
  endfunction

  function automatic logic [67:0] expv();
    logic [14:0] eu, ed;
    eu = (m_code >= 15) ? 15'h7FFF : 15'((1 << m_code) - 1);
    ed = (m_code > 15) ? 15'((1 << (m_code - 15)) - 1) : 15'h0000;
    return {5'(m_code), eu, ~eu, ed, ~ed, m_sh, m_sl, m_lock};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(bit en, bit ov, bit vld, bit up);
    dcc_en = en; ovr_en = ov; pd_vld = vld; pd_up = up;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_in(0, 0, 0, 0); ovr_code = 5'd0; rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    total++;
    if (act !== expv()) begin bad++; $display("FAIL reset_model act=%h exp=%h", act, expv()); end
    total++;
    if ({fine_code, therm_up, thermb_dn, therm_dn, thermb_up} !== {5'd15, 15'h7FFF, 15'h7FFF, 15'h0, 15'h0}) begin
      bad++; $display("FAIL reset_values code=%0d up=%h dn=%h", fine_code, therm_up, therm_dn);
    end
    rstb = 1'b1;
  endtask

  task automatic test_first_step();
    set_in(1, 0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 1, 1); tick();
      total++;
      if (act !== expv()) begin bad++; $display("FAIL step_vote%0d act=%h exp=%h", i, act, expv()); end
    end
    total++;
    if (fine_code !== 5'd16 || therm_dn !== 15'h0001) begin
      bad++; $display("FAIL step_16 code=%0d dn=%h want 16/0001", fine_code, therm_dn);
    end
    for (int i = 0; i < SETTLE_CYC + 4; i++) begin
      tick();
      total++;
      if (act !== expv()) begin bad++; $display("FAIL settle_c%0d act=%h exp=%h", i, act, expv()); end
    end
    total++;
    if (fine_code !== 5'd17) begin bad++; $display("FAIL step_17 code=%0d want 17", fine_code); end
  endtask

  task automatic test_restart();
    bit pat[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    int start;
    set_in(1, 0, 0, 0);
    repeat (SETTLE_CYC) tick();
    start = int'(fine_code);
    for (int i = 0; i < 8; i++) begin
      set_in(1, 0, 1, pat[i]); tick();
      total++;
      if (act !== expv()) begin bad++; $display("FAIL restart_v%0d act=%h exp=%h", i, act, expv()); end
    end
    total++;
    if (int'(fine_code) !== start + 1) begin
      bad++; $display("FAIL restart_one_step code=%0d want %0d", fine_code, start + 1);
    end
  endtask

  task automatic test_sat_hi();
    for (int b = 0; b < 16; b++) begin
      set_in(1, 0, 0, 0); repeat (SETTLE_CYC) tick();
      for (int i = 0; i < 4; i++) begin set_in(1, 0, 1, 1); tick(); end
      total++;
      if (act !== expv()) begin bad++; $display("FAIL sat_burst%0d act=%h exp=%h", b, act, expv()); end
    end
    total++;
    if (fine_code !== 5'd30 || therm_dn !== 15'h7FFF || sat_hi !== 1'b1) begin
      bad++; $display("FAIL sat_hi_top code=%0d dn=%h sat_hi=%b want 30/7fff/1", fine_code, therm_dn, sat_hi);
    end
    for (int i = 0; i < 4; i++) begin set_in(1, 0, 1, 0); tick(); end
    total++;
    if (fine_code !== 5'd29 || sat_hi !== 1'b0 || act !== expv()) begin
      bad++; $display("FAIL sat_release code=%0d sat_hi=%b want 29/0", fine_code, sat_hi);
    end
  endtask

  task automatic test_lock();
    set_in(0, 0, 0, 0); tick();
    set_in(1, 0, 0, 0); tick();
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < 4; i++) begin set_in(1, 0, 1, (s % 2) == 0); tick(); end
      total++;
      if (act !== expv()) begin bad++; $display("FAIL lock_step%0d act=%h exp=%h", s, act, expv()); end
      set_in(1, 0, 0, 0); repeat (SETTLE_CYC) tick();
    end
    total++;
    if (dcc_lock !== 1'b1) begin bad++; $display("FAIL lock_set lock=%b want 1", dcc_lock); end
    set_in(0, 0, 0, 0); tick();
    total++;
    if (dcc_lock !== 1'b0 || fine_code !== 5'd30 || act !== expv()) begin
      bad++; $display("FAIL lock_clear lock=%b code=%0d want 0/30", dcc_lock, fine_code);
    end
  endtask

  task automatic test_ovr();
    set_in(1, 1, 1, 0); ovr_code = 5'd31; tick();
    total++;
    if (fine_code !== 5'd30 || act !== expv()) begin
      bad++; $display("FAIL ovr_clamp code=%0d want 30", fine_code);
    end
    ovr_code = 5'd3; tick();
    total++;
    if (fine_code !== 5'd3 || therm_up !== 15'h0007) begin
      bad++; $display("FAIL ovr_code3 code=%0d up=%h want 3/0007", fine_code, therm_up);
    end
    ovr_code = 5'd31; tick();
    set_in(1, 0, 0, 0); tick(); tick();
    for (int i = 0; i < 4; i++) begin set_in(1, 0, 1, 0); tick(); end
    total++;
    if (fine_code !== 5'd29 || act !== expv()) begin
      bad++; $display("FAIL ovr_resume code=%0d want 29", fine_code);
    end
  endtask

  task automatic test_async_reset();
    set_in(1, 0, 0, 0); repeat (SETTLE_CYC) tick();
    for (int i = 0; i < 4; i++) begin set_in(1, 0, 1, 1); tick(); end
    tick(); tick();
    rstb = 1'b0;
    #2;
    model_reset();
    total++;
    if (act !== expv() || fine_code !== 5'd15) begin
      bad++; $display("FAIL async_reset act=%h exp=%h", act, expv());
    end
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic test_random();
    int target;
    target = $urandom_range(0, 30);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) target = $urandom_range(0, 30);
      dcc_en   = ($urandom_range(0, 299) != 0);
      ovr_en   = ($urandom_range(0, 299) < 2);
      ovr_code = 5'($urandom_range(0, 31));
      pd_vld   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) pd_up = $urandom_range(0, 1);
      else pd_up = (m_code <= target);
      tick();
      total++;
      if (act !== expv()) begin bad++; $display("FAIL random_c%0d act=%h exp=%h", c, act, expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_restart();
    test_sat_hi();
    test_lock();
    test_ovr();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
